// File: rtl/regf_pkg.sv
// Shared defaults and the address type for the multi-port register file.
package regf_pkg;

    localparam int                     REGF_DATA_W = 32;
    localparam int                     REGF_DEPTH  = 32;
    localparam int                     REGF_ADDR_W = $clog2(REGF_DEPTH);
    localparam int                     REGF_SP_IDX = 29;
    localparam logic [REGF_DATA_W-1:0] REGF_SP_RST = 128;

    typedef logic [REGF_ADDR_W-1:0] regf_addr_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-side bus of the register file: read ports, write ports, issue and busy.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    logic [NUM_WR-1:0]        wr_en_i;
    logic [NUM_WR*ADDR_W-1:0] wr_addr_i;
    logic [NUM_WR*DATA_W-1:0] wr_data_i;
    logic                     iss_en_i;
    logic [ADDR_W-1:0]        iss_addr_i;
    logic                     any_busy_o;

    modport slave (
        input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i,
        output rd_data_o, rd_busy_o, any_busy_o
    );

    modport master (
        output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i,
        input  rd_data_o, rd_busy_o, any_busy_o
    );
endinterface

// File: rtl/regf_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, issue wins on a tie.
module regf_scoreboard #(
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    output logic [DEPTH-1:0]         busy_o,
    output logic                     any_busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] clr;

    always_comb begin
        clr = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w]) begin
                clr[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (iss_en_i && iss_addr_i == ADDR_W'(r)) begin
                busy_d[r] = 1'b1;
            end else if (clr[r]) begin
                busy_d[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign any_busy_o = |busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with busy scoreboard.
// Optional write-through forwarding on reads: define REGF_BYPASS_EN.
module reg_file_mp
    import regf_pkg::*;
#(
    parameter int                DATA_W   = REGF_DATA_W,
    parameter int                DEPTH    = REGF_DEPTH,
    parameter int                ADDR_W   = $clog2(DEPTH),
    parameter int                NUM_RD   = 2,
    parameter int                NUM_WR   = 2,
    parameter int                ZERO_REG = 1,
    parameter int                SP_IDX   = REGF_SP_IDX,
    parameter logic [DATA_W-1:0] SP_RST   = REGF_SP_RST
) (
    input logic           clk_i,
    input logic           rst_i,
    reg_file_mp_if.slave  regf
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Ascending port order makes the highest-index writer win a collision.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (regf.wr_en_i[w]) begin
                regs_d[regf.wr_addr_i[w*ADDR_W +: ADDR_W]] = regf.wr_data_i[w*DATA_W +: DATA_W];
            end
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= (r == SP_IDX) ? SP_RST : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regf_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .iss_en_i   (regf.iss_en_i),
        .iss_addr_i (regf.iss_addr_i),
        .wr_en_i    (regf.wr_en_i),
        .wr_addr_i  (regf.wr_addr_i),
        .busy_o     (busy),
        .any_busy_o (regf.any_busy_o)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;
        logic              rbusy;

        assign ra = regf.rd_addr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            rdat  = regs_q[ra];
            rbusy = busy[ra];
`ifdef REGF_BYPASS_EN
            // A forwarded value is already produced, so it is only pending again if re-issued now.
            for (int w = 0; w < NUM_WR; w++) begin
                if (regf.wr_en_i[w] && regf.wr_addr_i[w*ADDR_W +: ADDR_W] == ra) begin
                    rdat  = regf.wr_data_i[w*DATA_W +: DATA_W];
                    rbusy = regf.iss_en_i && (regf.iss_addr_i == ra);
                end
            end
`endif
            if (ZERO_REG != 0 && ra == '0) begin
                rdat  = '0;
                rbusy = 1'b0;
            end
        end

        assign regf.rd_data_o[k*DATA_W +: DATA_W] = rdat;
        assign regf.rd_busy_o[k]                  = rbusy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp; forwarding expectations follow REGF_BYPASS_EN.
module tb_reg_file_mp;
    import regf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();

    reg_file_mp dut (
        .clk_i (clk),
        .rst_i (rst),
        .regf  (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en_i  = '0;
        bus.iss_en_i = 1'b0;
    endtask

    task automatic wr(input int p, input regf_addr_t a, input logic [31:0] d);
        bus.wr_en_i[p]             = 1'b1;
        bus.wr_addr_i[p*5 +: 5]    = a;
        bus.wr_data_i[p*32 +: 32]  = d;
    endtask

    task automatic iss(input regf_addr_t a);
        bus.iss_en_i   = 1'b1;
        bus.iss_addr_i = a;
    endtask

    task automatic rd(input regf_addr_t a0, input regf_addr_t a1);
        bus.rd_addr_i = {a1, a0};
        #1;
    endtask

    initial begin
        bus.rd_addr_i  = '0;
        bus.wr_en_i    = '0;
        bus.wr_addr_i  = '0;
        bus.wr_data_i  = '0;
        bus.iss_en_i   = 1'b0;
        bus.iss_addr_i = '0;

        // reset for one cycle
        tick();
        rst = 1'b0;
        rd(5'd29, 5'd0);
        check("rst_sp",    64'(bus.rd_data_o[31:0]),  64'd128);
        check("rst_r0",    64'(bus.rd_data_o[63:32]), 64'd0);
        check("rst_busy",  64'(bus.rd_busy_o),        64'd0);
        check("rst_any",   64'(bus.any_busy_o),       64'd0);
        rd(5'd5, 5'd31);
        check("rst_r5",    64'(bus.rd_data_o[31:0]),  64'd0);
        check("rst_r31",   64'(bus.rd_data_o[63:32]), 64'd0);

        // plain write then read on both ports
        wr(0, 5'd5, 32'hDEADBEEF);
        tick(); idle();
        rd(5'd5, 5'd5);
        check("wr_r5_p0",  64'(bus.rd_data_o[31:0]),  64'hDEADBEEF);
        check("wr_r5_p1",  64'(bus.rd_data_o[63:32]), 64'hDEADBEEF);

        wr(1, 5'd0, 32'h1234);
        tick(); idle();
        rd(5'd0, 5'd0);
        check("wr_r0",     64'(bus.rd_data_o[31:0]),  64'd0);

        // same-address collision and independent dual write
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        tick(); idle();
        rd(5'd7, 5'd5);
        check("coll_r7",   64'(bus.rd_data_o[31:0]),  64'h22);
        check("keep_r5",   64'(bus.rd_data_o[63:32]), 64'hDEADBEEF);

        wr(0, 5'd8, 32'h33);
        wr(1, 5'd6, 32'h44);
        tick(); idle();
        rd(5'd8, 5'd6);
        check("dual_r8",   64'(bus.rd_data_o[31:0]),  64'h33);
        check("dual_r6",   64'(bus.rd_data_o[63:32]), 64'h44);

        // scoreboard set / clear / set-wins
        iss(5'd9);
        tick(); idle();
        rd(5'd9, 5'd10);
        check("sb_set",    64'(bus.rd_busy_o[0]),     64'd1);
        check("sb_other",  64'(bus.rd_busy_o[1]),     64'd0);
        check("sb_any1",   64'(bus.any_busy_o),       64'd1);

        wr(1, 5'd9, 32'h55);
        tick(); idle();
        rd(5'd9, 5'd9);
        check("sb_clr",    64'(bus.rd_busy_o[0]),     64'd0);
        check("sb_clr_d",  64'(bus.rd_data_o[63:32]), 64'h55);
        check("sb_any0",   64'(bus.any_busy_o),       64'd0);

        iss(5'd9);
        wr(0, 5'd9, 32'h66);
        tick(); idle();
        rd(5'd9, 5'd0);
        check("sb_tie",    64'(bus.rd_busy_o[0]),     64'd1);
        check("sb_tie_d",  64'(bus.rd_data_o[31:0]),  64'h66);

        wr(0, 5'd11, 32'h99);
        tick(); idle();
        rd(5'd11, 5'd0);
        check("sb_wb_idle", 64'(bus.rd_busy_o[0]),    64'd0);

        iss(5'd0);
        tick(); idle();
        rd(5'd0, 5'd9);
        check("sb_r0",     64'(bus.rd_busy_o[0]),     64'd0);
        check("sb_r9_hold", 64'(bus.rd_busy_o[1]),    64'd1);

        // reset in the middle of traffic
        wr(0, 5'd3, 32'h77);
        tick(); idle();
        iss(5'd3);
        tick(); idle();
        rd(5'd3, 5'd3);
        check("pre_r3_d",  64'(bus.rd_data_o[31:0]),  64'h77);
        check("pre_r3_b",  64'(bus.rd_busy_o[0]),     64'd1);

        rst = 1'b1;
        wr(1, 5'd3, 32'hABCD);
        iss(5'd4);
        tick(); idle();
        rst = 1'b0;
        rd(5'd3, 5'd4);
        check("mid_r3",    64'(bus.rd_data_o[31:0]),  64'd0);
        check("mid_r4_b",  64'(bus.rd_busy_o[1]),     64'd0);
        check("mid_any",   64'(bus.any_busy_o),       64'd0);
        rd(5'd29, 5'd5);
        check("mid_sp",    64'(bus.rd_data_o[31:0]),  64'd128);
        check("mid_r5",    64'(bus.rd_data_o[63:32]), 64'd0);

        // same-cycle read of a register being written
        wr(0, 5'd12, 32'h1111);
        tick(); idle();
        wr(1, 5'd12, 32'hA5A5);
        wr(0, 5'd0, 32'hFFFF);
        rd(5'd12, 5'd0);
`ifdef REGF_BYPASS_EN
        check("byp_data",  64'(bus.rd_data_o[31:0]),  64'hA5A5);
`else
        check("byp_data",  64'(bus.rd_data_o[31:0]),  64'h1111);
`endif
        check("byp_busy",  64'(bus.rd_busy_o[0]),     64'd0);
        check("byp_r0",    64'(bus.rd_data_o[63:32]), 64'd0);
        tick(); idle();
        rd(5'd12, 5'd12);
        check("post_r12",  64'(bus.rd_data_o[31:0]),  64'hA5A5);

        iss(5'd13);
        tick(); idle();
        wr(0, 5'd13, 32'hBB);
        rd(5'd13, 5'd12);
`ifdef REGF_BYPASS_EN
        check("byp_b13",   64'(bus.rd_busy_o[0]),     64'd0);
`else
        check("byp_b13",   64'(bus.rd_busy_o[0]),     64'd1);
`endif
        iss(5'd13);
        #1;
`ifdef REGF_BYPASS_EN
        check("byp_b13_iss", 64'(bus.rd_busy_o[0]),   64'd1);
`else
        check("byp_b13_iss", 64'(bus.rd_busy_o[0]),   64'd1);
`endif
        bus.iss_en_i = 1'b0;
        tick(); idle();
        rd(5'd13, 5'd13);
        check("post_b13",  64'(bus.rd_busy_o[0]),     64'd0);
        check("post_d13",  64'(bus.rd_data_o[63:32]), 64'hBB);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the pipelined CPU, successor to the 2R/1W 32x32 register file.
- Width, depth, read-port count and write-port count are parameters; the stack-pointer reset value is programmable.
- Adds a per-register busy scoreboard (set at issue, cleared at writeback) that the hazard unit reads to stall.
- Sits between the decode stage (reads, issue) and the writeback stage (writes).

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of registers (power of 2, >=2)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
NUM_RD, 2, read ports
NUM_WR, 2, write ports; higher index = younger/priority
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
SP_IDX, 29, index of register with nonzero reset value
SP_RST, 128, reset value of register SP_IDX

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
rd_addr_i  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data_o  out  NUM_RD*DATA_W  read data, packed the same way
rd_busy_o  out  NUM_RD  busy bit of the addressed register per read port
wr_en_i  in  NUM_WR  write enables
wr_addr_i  in  NUM_WR*ADDR_W  write addresses
wr_data_i  in  NUM_WR*DATA_W  write data
iss_en_i  in  1  mark a destination register pending
iss_addr_i  in  ADDR_W  destination being issued
any_busy_o  out  1  OR of all busy bits (drain detect)

Behaviour:
- Reset: synchronous; rst_i=1 at a clock edge clears all registers to 0 except SP_IDX <= SP_RST, and clears all busy bits. rst_i dominates all writes and issues in that cycle.
- Outputs while reset is held, from the next edge onward: rd_data_o reflects reset contents; rd_busy_o=0; any_busy_o=0.
- Reads: combinational, zero-latency, from current array contents.
- ZERO_REG=1: address 0 always returns 0 with busy 0.
- Writes: at the edge, for each port with wr_en_i=1, reg[wr_addr] <= wr_data.
- Write collision: two ports with the same address in the same cycle: the highest-index port wins.
- Writes to reg 0 are dropped when ZERO_REG=1.
- Busy scoreboard, next-state per register r:
  - set if iss_en_i && iss_addr_i==r;
  - else clear if any wr_en_i with wr_addr==r;
  - else hold.
  - Simultaneous issue and writeback to the same r: set wins (the new producer is still pending).
- Issue to an already-busy register leaves it busy. There is no counting; the pipeline guarantees in-order writeback per register.
- Writeback to a non-busy register is legal: data is written, busy stays 0.
- Out-of-range addresses cannot occur (DEPTH is a power of 2).

Optional Feature:
- Macro REGF_BYPASS_EN.
- Defined: write-through forwarding. If a read address matches an enabled write port's address in the same cycle, rd_data_o returns that wr_data_i, with the highest-index matching port winning. rd_busy_o for that port is forced to 0, unless the same cycle's issue targets that address.
- ZERO_REG still forces 0 on address 0.
- Undefined: reads return the pre-edge array value; busy reflects registered state only.

Decomposition:
- Shared package regf_pkg holds:
  - default constants REGF_DATA_W, REGF_DEPTH, REGF_SP_IDX, REGF_SP_RST;
  - the typedef regf_addr_t.
- One natural sub-module, regf_scoreboard: busy-bit vector with set/clear priority and the any_busy_o reduction.
- The data array, write-collision logic and read muxes stay in reg_file_mp.

Test Plan:
- Reset: rst_i=1 for 1 cycle -> all reads 0 except reg 29 = 128; rd_busy_o=0; any_busy_o=0.
- Write/read: wr port0 r5=0xDEADBEEF; next cycle read r5 on both ports -> 0xDEADBEEF. Write r0=0x1234 -> r0 reads 0.
- Collision: port0 r7=0x11 and port1 r7=0x22 in the same cycle -> r7 reads 0x22.
- Scoreboard: issue r9 -> next cycle rd_busy=1, any_busy_o=1. Writeback r9=0x55 -> busy clears next cycle. Issue r9 plus writeback r9 in the same cycle -> busy stays 1.
- Reset mid-operation: r3 busy with data 0x77, assert rst_i while a write to r3 and an issue to r4 are both active -> r3=0, r4 not busy, any_busy_o=0.
- With REGF_BYPASS_EN: read r12 while port1 writes r12=0xA5A5 -> rd_data_o=0xA5A5 in the same cycle, busy=0. Without the macro -> old value is returned in that cycle.
